// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: main/side junction phase sequencer with 1 s prescaler and latched side demand.
// Optional night flashing mode is compiled in with `define NIGHT_MODE_EN.
module traffic_light_ctrl #(
    parameter int unsigned CLK_PER_SEC = 100000000,
    parameter int unsigned T_ALL_RED   = 1,
    parameter int unsigned T_RED_YEL   = 1,
    parameter int unsigned T_GREEN     = 10,
    parameter int unsigned T_YELLOW    = 2
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       REQ_S,
`ifdef NIGHT_MODE_EN
    input  logic       NIGHT,
`endif
    output logic [2:0] M_LIGHT,
    output logic [2:0] S_LIGHT,
    output logic [3:0] PHASE,
    output logic       PHASE_TICK
);
    typedef enum logic [3:0] {
        AR_A  = 4'd0,
        M_RY  = 4'd1,
        M_G   = 4'd2,
        M_Y   = 4'd3,
        AR_B  = 4'd4,
        S_RY  = 4'd5,
        S_G   = 4'd6,
        S_Y   = 4'd7,
        FLASH = 4'd8
    } state_t;

    localparam logic [31:0] PRE_MAX = 32'(CLK_PER_SEC - 1);
    localparam logic [7:0]  T_AR    = 8'(T_ALL_RED);
    localparam logic [7:0]  T_RY    = 8'(T_RED_YEL);
    localparam logic [7:0]  T_G     = 8'(T_GREEN);
    localparam logic [7:0]  T_Y     = 8'(T_YELLOW);

    state_t      state, state_nxt, state_prv, seq_nxt;
    logic [31:0] presc;
    logic [7:0]  sec, t_cur;
    logic        req_pending, sec_tick, phase_end, expired, night_req;

`ifdef NIGHT_MODE_EN
    assign night_req = NIGHT;
`else
    assign night_req = 1'b0;
`endif

    assign sec_tick  = presc == PRE_MAX;
    assign phase_end = sec_tick && sec == t_cur - 8'd1;
    // Main green past its minimum parks with sec saturated at T_G until demand arrives
    assign expired   = state == M_G && sec == T_G;
    assign PHASE     = state;

    always_comb begin
        t_cur = T_AR;
        case (state)
            M_RY, S_RY: t_cur = T_RY;
            M_G,  S_G:  t_cur = T_G;
            M_Y,  S_Y:  t_cur = T_Y;
            default:    t_cur = T_AR;
        endcase
    end

    always_comb begin
        seq_nxt   = AR_A;
        state_nxt = state;
        case (state)
            AR_A:    seq_nxt = M_RY;
            M_RY:    seq_nxt = M_G;
            M_G:     seq_nxt = M_Y;
            M_Y:     seq_nxt = AR_B;
            AR_B:    seq_nxt = S_RY;
            S_RY:    seq_nxt = S_G;
            S_G:     seq_nxt = S_Y;
            default: seq_nxt = AR_A;
        endcase
        if (state == FLASH)
            state_nxt = (sec_tick && !night_req) ? AR_A : FLASH;
        else if (phase_end || expired)
            state_nxt = night_req ? FLASH : (state == M_G && !req_pending) ? M_G : seq_nxt;
    end

    always_comb begin
        M_LIGHT = 3'b100;
        S_LIGHT = 3'b100;
        case (state)
            M_RY:    M_LIGHT = 3'b110;
            M_G:     M_LIGHT = 3'b001;
            M_Y:     M_LIGHT = 3'b010;
            S_RY:    S_LIGHT = 3'b110;
            S_G:     S_LIGHT = 3'b001;
            S_Y:     S_LIGHT = 3'b010;
            FLASH: begin
                M_LIGHT = sec[0] ? 3'b000 : 3'b010;
                S_LIGHT = sec[0] ? 3'b000 : 3'b010;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state       <= AR_A;
            state_prv   <= AR_A;
            PHASE_TICK  <= 1'b0;
            presc       <= '0;
            sec         <= '0;
            req_pending <= 1'b0;
        end else begin
            state      <= state_nxt;
            state_prv  <= state;
            PHASE_TICK <= state != state_prv;
            if (state_nxt != state) begin
                presc <= '0;
                sec   <= '0;
            end else if (!expired) begin
                presc <= sec_tick ? '0 : presc + 32'd1;
                sec   <= sec_tick ? sec + 8'd1 : sec;
            end
            // Demand on the first S_G cycle counts as served; FLASH freezes it
            if (state == S_G && state_prv != S_G)
                req_pending <= 1'b0;
            else if (REQ_S && state != FLASH)
                req_pending <= 1'b1;
        end
    end
endmodule
